// File: rtl/mult_prof_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mult_prof_pkg                                               |
// | Purpose  : Shared types and width helpers for the multiplier error     |
// |            profiler (FSM state encoding, product/count/sum widths).    |
// | Ports    : none (package)                                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package mult_prof_pkg;

   localparam int PROF_STATE_W = 2;

   typedef enum logic [PROF_STATE_W-1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } prof_state_t;

   // Product of two W-bit operands.
   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

   // Error count must hold 2^(2W) (every pair wrong), hence one extra bit.
   function automatic int cnt_w(input int w);
      return 2 * w + 1;
   endfunction

   // Sum of up to 2^(2W) distances each below 2^(2W).
   function automatic int sum_w(input int w);
      return 4 * w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ed_accum.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ed_accum                                                    |
// | Purpose  : Compares one tail sample of the profiler delay line against |
// |            its exact product and accumulates error metrics.            |
// | Ports    : clk, rst_n (sync, active-low), clear_i (start of run),      |
// |            valid_i, a_i/b_i (operands), exact_i, y_i (DUT product),    |
// |            err_count_o, sum_ed_o, max_ed_o, first_err_valid_o,         |
// |            first_err_a_o, first_err_b_o                                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module ed_accum
   import mult_prof_pkg::*;
#(
   parameter int W = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear_i,
   input  logic               valid_i,
   input  logic [W-1:0]       a_i,
   input  logic [W-1:0]       b_i,
   input  logic [2*W-1:0]     exact_i,
   input  logic [2*W-1:0]     y_i,
   output logic [2*W:0]       err_count_o,
   output logic [4*W-1:0]     sum_ed_o,
   output logic [2*W-1:0]     max_ed_o,
   output logic               first_err_valid_o,
   output logic [W-1:0]       first_err_a_o,
   output logic [W-1:0]       first_err_b_o
);

   localparam int PW = prod_w(W);
   localparam int CW = cnt_w(W);
   localparam int SW = sum_w(W);

   logic [PW:0]   w_diff;
   logic [PW-1:0] w_ed;
   logic          w_err;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] sum_q, sum_d;
   logic [PW-1:0] max_q, max_d;
   logic          fv_q, fv_d;
   logic [W-1:0]  fa_q, fa_d;
   logic [W-1:0]  fb_q, fb_d;

   // The extra top bit of the difference is the sign; on a negative result
   // the magnitude is taken from the reversed subtraction.
   assign w_diff = {1'b0, y_i} - {1'b0, exact_i};
   assign w_ed   = w_diff[PW] ? (exact_i - y_i) : w_diff[PW-1:0];
   assign w_err  = valid_i && (w_ed != '0);

   always_comb begin
      cnt_d = cnt_q;
      sum_d = sum_q;
      max_d = max_q;
      fv_d  = fv_q;
      fa_d  = fa_q;
      fb_d  = fb_q;
      if (clear_i) begin
         cnt_d = '0;
         sum_d = '0;
         max_d = '0;
         fv_d  = 1'b0;
         fa_d  = '0;
         fb_d  = '0;
      end else if (w_err) begin
         cnt_d = cnt_q + 1'b1;
         sum_d = sum_q + SW'(w_ed);
         if (w_ed > max_q) begin
            max_d = w_ed;
         end
         if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_i;
            fb_d = b_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sum_q <= '0;
         max_q <= '0;
         fv_q  <= 1'b0;
         fa_q  <= '0;
         fb_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sum_q <= sum_d;
         max_q <= max_d;
         fv_q  <= fv_d;
         fa_q  <= fa_d;
         fb_q  <= fb_d;
      end
   end

   assign err_count_o       = cnt_q;
   assign sum_ed_o          = sum_q;
   assign max_ed_o          = max_q;
   assign first_err_valid_o = fv_q;
   assign first_err_a_o     = fa_q;
   assign first_err_b_o     = fb_q;

endmodule
`default_nettype wire

// File: rtl/mult_error_profiler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mult_error_profiler                                         |
// | Purpose  : Exhaustive on-chip error profiler for a WxW multiplier.     |
// |            Sweeps all operand pairs (b outer, a inner), aligns each    |
// |            pair with the DUT product through a DUT_LAT+1 delay line    |
// |            and accumulates error-distance metrics.                     |
// | Ports    : clk, rst_n (sync, active-low), start, op_a/op_b (to DUT),   |
// |            dut_y (from DUT), busy, done, err_count, sum_ed, max_ed,    |
// |            first_err_valid, first_err_a, first_err_b                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mult_error_profiler
   import mult_prof_pkg::*;
#(
   parameter int W       = 8,
   parameter int DUT_LAT = 0
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [W-1:0]       op_a,
   output logic [W-1:0]       op_b,
   input  logic [2*W-1:0]     dut_y,
   output logic               busy,
   output logic               done,
   output logic [2*W:0]       err_count,
   output logic [4*W-1:0]     sum_ed,
   output logic [2*W-1:0]     max_ed,
   output logic               first_err_valid,
   output logic [W-1:0]       first_err_a,
   output logic [W-1:0]       first_err_b
);

   localparam int PW    = prod_w(W);
   localparam int DEPTH = DUT_LAT + 1;

   prof_state_t state_q, state_d;
   logic [PW-1:0] idx_q, idx_d;
   logic [W-1:0]  op_a_q, op_b_q;
   logic          busy_q, done_q;

   // Stage 0 is loaded together with op_a/op_b; the tail stage lines up with
   // the edge at which dut_y for that pair is valid.
   logic [DEPTH-1:0]        pipe_v_q;
   logic [DEPTH-1:0][W-1:0] pipe_a_q;
   logic [DEPTH-1:0][W-1:0] pipe_b_q;

   logic          w_issue;
   logic          w_clear;
   logic          w_finish;
   logic          w_idx_last;
   logic          w_pipe_empty;
   logic [PW-1:0] w_exact;

   assign w_idx_last   = &idx_q;
   assign w_pipe_empty = (pipe_v_q == '0);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)        state_d = SWEEP;
         SWEEP:   if (w_idx_last)   state_d = DRAIN;
         DRAIN:   if (w_pipe_empty) state_d = DONE;
         DONE:    if (start)        state_d = SWEEP;
         default:                   state_d = IDLE;
      endcase
   end

   // Control strobes
   always_comb begin
      w_issue  = (state_q == SWEEP);
      w_clear  = ((state_q == IDLE) || (state_q == DONE)) && start;
      w_finish = (state_q == DRAIN) && w_pipe_empty;
   end

   // The index holds at all-ones on the final issue rather than wrapping.
   always_comb begin
      idx_d = idx_q;
      if (w_clear) begin
         idx_d = '0;
      end else if (w_issue && !w_idx_last) begin
         idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q    <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pipe_v_q <= '0;
         pipe_a_q <= '0;
         pipe_b_q <= '0;
      end else begin
         idx_q  <= idx_d;
         done_q <= w_finish;
         if (w_issue) begin
            op_a_q <= idx_q[W-1:0];
            op_b_q <= idx_q[PW-1:W];
            busy_q <= 1'b1;
         end else if (w_finish) begin
            busy_q <= 1'b0;
         end
         pipe_v_q[0] <= w_issue;
         pipe_a_q[0] <= idx_q[W-1:0];
         pipe_b_q[0] <= idx_q[PW-1:W];
         for (int i = 1; i < DEPTH; i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            pipe_a_q[i] <= pipe_a_q[i-1];
            pipe_b_q[i] <= pipe_b_q[i-1];
         end
      end
   end

   assign w_exact = PW'(pipe_a_q[DEPTH-1]) * PW'(pipe_b_q[DEPTH-1]);

   ed_accum #(
      .W (W)
   ) u_ed_accum (
      .clk               (clk),
      .rst_n             (rst_n),
      .clear_i           (w_clear),
      .valid_i           (pipe_v_q[DEPTH-1]),
      .a_i               (pipe_a_q[DEPTH-1]),
      .b_i               (pipe_b_q[DEPTH-1]),
      .exact_i           (w_exact),
      .y_i               (dut_y),
      .err_count_o       (err_count),
      .sum_ed_o          (sum_ed),
      .max_ed_o          (max_ed),
      .first_err_valid_o (first_err_valid),
      .first_err_a_o     (first_err_a),
      .first_err_b_o     (first_err_b)
   );

   assign op_a = op_a_q;
   assign op_b = op_b_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_error_profiler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mult_error_profiler                                      |
// | Purpose  : Self-checking bench for mult_error_profiler. Three profiler |
// |            instances (W=4 LAT=0, W=4 LAT=2, W=8 LAT=0) drive modelled  |
// |            multipliers; expected metrics come from a reference model   |
// |            that walks every operand pair with plain arithmetic.        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_mult_error_profiler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start;
   int   sel;
   int   mode;
   logic misalign;
   logic [7:0] fault_tab [256];

   int n_cmp = 0;
   int n_bad = 0;

   // Multiplier models: 0 exact, 1 Y[0] forced 0, 2 constant 0, 3 random faults
   function automatic logic [7:0] f4(input int md, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = {4'b0, a} * {4'b0, b};
      case (md)
         1:       f4 = p & 8'hFE;
         2:       f4 = 8'h00;
         3:       f4 = p ^ fault_tab[{b, a}];
         default: f4 = p;
      endcase
   endfunction

   // ---------------- instance A: W=4, DUT_LAT=0 ----------------
   logic [3:0]  a_opa, a_opb, a_fa, a_fb;
   logic [7:0]  a_y, a_max, a_comb, a_s1, a_s2;
   logic [8:0]  a_cnt;
   logic [15:0] a_sum;
   logic        a_busy, a_done, a_fv, a_start;

   always_comb a_comb = f4(mode, a_opa, a_opb);
   always @(posedge clk) begin
      a_s1 <= a_comb;
      a_s2 <= a_s1;
   end
   assign a_y = misalign ? a_s2 : a_comb;
   assign a_start = start && (sel == 0);

   mult_error_profiler #(.W(4), .DUT_LAT(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .op_a(a_opa), .op_b(a_opb),
      .dut_y(a_y), .busy(a_busy), .done(a_done), .err_count(a_cnt),
      .sum_ed(a_sum), .max_ed(a_max), .first_err_valid(a_fv),
      .first_err_a(a_fa), .first_err_b(a_fb));

   // ---------------- instance B: W=4, DUT_LAT=2 ----------------
   logic [3:0]  b_opa, b_opb, b_fa, b_fb;
   logic [7:0]  b_y, b_max, b_comb, b_s1;
   logic [8:0]  b_cnt;
   logic [15:0] b_sum;
   logic        b_busy, b_done, b_fv, b_start;

   always_comb b_comb = f4(mode, b_opa, b_opb);
   always @(posedge clk) begin
      b_s1 <= b_comb;
      b_y  <= b_s1;
   end
   assign b_start = start && (sel == 1);

   mult_error_profiler #(.W(4), .DUT_LAT(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .op_a(b_opa), .op_b(b_opb),
      .dut_y(b_y), .busy(b_busy), .done(b_done), .err_count(b_cnt),
      .sum_ed(b_sum), .max_ed(b_max), .first_err_valid(b_fv),
      .first_err_a(b_fa), .first_err_b(b_fb));

   // ---------------- instance C: W=8, DUT_LAT=0, Y[0] forced 0 ----------------
   logic [7:0]  c_opa, c_opb, c_fa, c_fb;
   logic [15:0] c_y, c_max;
   logic [16:0] c_cnt;
   logic [31:0] c_sum;
   logic        c_busy, c_done, c_fv, c_start;

   assign c_y = ({8'b0, c_opa} * {8'b0, c_opb}) & 16'hFFFE;
   assign c_start = start && (sel == 2);

   mult_error_profiler #(.W(8), .DUT_LAT(0)) u_c (
      .clk(clk), .rst_n(rst_n), .start(c_start), .op_a(c_opa), .op_b(c_opb),
      .dut_y(c_y), .busy(c_busy), .done(c_done), .err_count(c_cnt),
      .sum_ed(c_sum), .max_ed(c_max), .first_err_valid(c_fv),
      .first_err_a(c_fa), .first_err_b(c_fb));

   // ---------------- observation mux ----------------
   logic [63:0] m_opa, m_opb, m_cnt, m_sum, m_max, m_fa, m_fb;
   logic        m_busy, m_done, m_fv;

   always_comb begin
      m_opa = 64'(c_opa); m_opb = 64'(c_opb); m_cnt = 64'(c_cnt);
      m_sum = 64'(c_sum); m_max = 64'(c_max); m_fa = 64'(c_fa);
      m_fb = 64'(c_fb); m_busy = c_busy; m_done = c_done; m_fv = c_fv;
      if (sel == 0) begin
         m_opa = 64'(a_opa); m_opb = 64'(a_opb); m_cnt = 64'(a_cnt);
         m_sum = 64'(a_sum); m_max = 64'(a_max); m_fa = 64'(a_fa);
         m_fb = 64'(a_fb); m_busy = a_busy; m_done = a_done; m_fv = a_fv;
      end else if (sel == 1) begin
         m_opa = 64'(b_opa); m_opb = 64'(b_opb); m_cnt = 64'(b_cnt);
         m_sum = 64'(b_sum); m_max = 64'(b_max); m_fa = 64'(b_fa);
         m_fb = 64'(b_fb); m_busy = b_busy; m_done = b_done; m_fv = b_fv;
      end
   end

   typedef struct {
      string  name;
      int     inst;
      int     md;
      int     mid_start;
      int     done_edge;
      longint cnt;
      longint sum;
      longint mx;
      int     fv;
      int     fa;
      int     fb;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: walk every pair in sweep order with integer arithmetic.
   task automatic model4(input int md, inout vec_t r);
      r.cnt = 0; r.sum = 0; r.mx = 0; r.fv = 0; r.fa = 0; r.fb = 0;
      for (int b = 0; b < 16; b++) begin
         for (int a = 0; a < 16; a++) begin
            int p, y, ed;
            p  = a * b;
            y  = int'(f4(md, 4'(a), 4'(b)));
            ed = (y > p) ? (y - p) : (p - y);
            if (ed != 0) begin
               r.cnt++;
               r.sum += ed;
               if (ed > r.mx) r.mx = ed;
               if (r.fv == 0) begin
                  r.fv = 1; r.fa = a; r.fb = b;
               end
            end
         end
      end
   endtask

   task automatic chk_metrics(input vec_t v);
      chk({v.name, "_err_count"}, m_cnt, 64'(v.cnt));
      chk({v.name, "_sum_ed"}, m_sum, 64'(v.sum));
      chk({v.name, "_max_ed"}, m_max, 64'(v.mx));
      chk({v.name, "_first_valid"}, 64'(m_fv), 64'(v.fv));
      chk({v.name, "_first_a"}, m_fa, 64'(v.fa));
      chk({v.name, "_first_b"}, m_fb, 64'(v.fb));
   endtask

   // Pulses start before edge 0, then counts edges until done is observed.
   task automatic run_vec(input vec_t v, input int bound);
      int e;
      sel  = v.inst;
      mode = v.md;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e = 0;
      while (e <= bound) begin
         @(posedge clk);
         #1;
         e++;
         if (e == 1) begin
            chk({v.name, "_first_op_a"}, m_opa, 64'd0);
            chk({v.name, "_first_op_b"}, m_opb, 64'd0);
            chk({v.name, "_busy_running"}, 64'(m_busy), 64'd1);
         end
         if (v.mid_start != 0 && e == 60) start = 1'b1;
         if (e == 61) start = 1'b0;
         if (m_done) break;
      end
      chk({v.name, "_done_edge"}, 64'(e), 64'(v.done_edge));
      chk({v.name, "_busy_at_done"}, 64'(m_busy), 64'd0);
      chk_metrics(v);
      @(posedge clk);
      #1;
      chk({v.name, "_done_one_cycle"}, 64'(m_done), 64'd0);
      chk({v.name, "_held_err_count"}, m_cnt, 64'(v.cnt));
   endtask

   initial begin
      vec_t v;
      int e, e1, e2, ndone;

      rst_n = 1'b0; start = 1'b0; sel = 0; mode = 0; misalign = 1'b0;
      for (int i = 0; i < 256; i++)
         fault_tab[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;

      // Table: spec constants for fixed models, reference model for random faults.
      vecs.push_back('{"a_exact",   0, 0, 0, 258, 0,   0,     0,   0, 0, 0});
      vecs.push_back('{"a_y0zero",  0, 1, 0, 258, 64,  64,    1,   1, 1, 1});
      vecs.push_back('{"a_const0",  0, 2, 1, 258, 225, 14400, 225, 1, 1, 1});
      v = '{"a_random", 0, 3, 0, 258, 0, 0, 0, 0, 0, 0};
      model4(3, v);
      vecs.push_back(v);
      vecs.push_back('{"b_exact",   1, 0, 0, 260, 0,   0,     0,   0, 0, 0});
      v = '{"b_random", 1, 3, 1, 260, 0, 0, 0, 0, 0, 0};
      model4(3, v);
      vecs.push_back(v);
      vecs.push_back('{"b_const0",  1, 2, 0, 260, 225, 14400, 225, 1, 1, 1});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_op_a", m_opa, 64'd0);
      chk("reset_op_b", m_opb, 64'd0);
      chk("reset_busy", 64'(m_busy), 64'd0);
      chk("reset_done", 64'(m_done), 64'd0);
      chk("reset_err_count", m_cnt, 64'd0);
      chk("reset_first_valid", 64'(m_fv), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], 2000);

      // Reset mid-sweep, then a clean rerun must match the table.
      sel = 0; mode = 2;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("midrst_busy_before", 64'(m_busy), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_op_a", m_opa, 64'd0);
      chk("midrst_op_b", m_opb, 64'd0);
      chk("midrst_busy", 64'(m_busy), 64'd0);
      chk("midrst_done", 64'(m_done), 64'd0);
      chk("midrst_err_count", m_cnt, 64'd0);
      chk("midrst_sum_ed", m_sum, 64'd0);
      chk("midrst_max_ed", m_max, 64'd0);
      chk("midrst_first_valid", 64'(m_fv), 64'd0);
      chk("midrst_first_a", m_fa, 64'd0);
      chk("midrst_first_b", m_fb, 64'd0);
      rst_n = 1'b1;
      v = vecs[2];
      v.name = "a_after_rst";
      v.mid_start = 0;
      run_vec(v, 2000);

      // Start held high: back-to-back runs, one done pulse each.
      sel = 0; mode = 2;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      e = 0; e1 = -1; e2 = -1; ndone = 0;
      while (e < 2000 && e2 < 0) begin
         @(posedge clk);
         #1;
         e++;
         if (m_done) begin
            ndone++;
            if (e1 < 0) begin
               e1 = e;
               chk("hold_run1_err_count", m_cnt, 64'd225);
               chk("hold_run1_sum_ed", m_sum, 64'd14400);
            end else begin
               e2 = e;
            end
         end
         if (e1 > 0 && e == e1 + 1) begin
            chk("hold_restart_err_count", m_cnt, 64'd0);
            chk("hold_restart_sum_ed", m_sum, 64'd0);
            chk("hold_restart_first_valid", 64'(m_fv), 64'd0);
            chk("hold_restart_done", 64'(m_done), 64'd0);
         end
      end
      start = 1'b0;
      chk("hold_done1_edge", 64'(e1), 64'd258);
      chk("hold_done2_edge", 64'(e2), 64'd517);
      chk("hold_done_pulses", 64'(ndone), 64'd2);
      chk("hold_run2_err_count", m_cnt, 64'd225);
      chk("hold_run2_max_ed", m_max, 64'd225);

      // Registered DUT seen with DUT_LAT=0 must report errors.
      misalign = 1'b1;
      sel = 0; mode = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      e = 0;
      while (e < 2000 && !m_done) begin
         @(posedge clk);
         #1;
         e++;
      end
      chk("misalign_done_edge", 64'(e), 64'd258);
      chk("misalign_has_errors", 64'(m_cnt != 0), 64'd1);
      misalign = 1'b0;

      // Full W=8 sweep with Y[0] forced to 0.
      v = '{"c_y0zero", 2, 1, 0, 65538, 16384, 16384, 1, 1, 1, 1};
      run_vec(v, 70000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
